bmp_pixel_source: RTL and testbench

- Hardware pixel streamer for the RGB filter pipeline: reads a 24-bit BMP pixel array (BGR byte order, bottom-up rows) from a byte-wide memory.
- Assembles each pixel and drives red_o/green_o/blue_o qualified by done_o, the same strobe the median and RGB filter blocks take on done_i.
- Sits upstream of the filter chain; replaces the bench-side file reader in synthesizable flows.

---
 rtl/bmp_pixel_source.sv | 190 +++++++++++++++++++
 tb/tb_bmp_pixel_source.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_pixel_source.sv
// Streams 24-bit BGR pixels from a byte-wide memory as red/green/blue qualified by done_o.
// Optional ROW_PAD_EN: skip BMP row padding at each row end so any image width is supported.
module bmp_pixel_source #(
    parameter int ADDR_W = 20,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic [DIM_W-1:0]  height_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    input  logic              ready_i,
    output logic [7:0]        red_o,
    output logic [7:0]        green_o,
    output logic [7:0]        blue_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        CAP  = 3'd4,
        OUT  = 3'd5,
        FIN  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIM_W-1:0]  width_q, width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [7:0]        red_q, red_d;
    logic [7:0]        green_q, green_d;
    logic [7:0]        blue_q, blue_d;
    logic              busy_q, busy_d;

    logic              last_col;
    logic              last_row;
    logic [ADDR_W-1:0] row_step;

    assign last_col = (col_q == width_q - DIM_W'(1));
    assign last_row = (row_q == height_q - DIM_W'(1));

`ifdef ROW_PAD_EN
    // BMP rows are padded to a 4-byte boundary: pad = (4 - (3*width mod 4)) mod 4.
    logic [3:0] three_w_mod;
    logic [2:0] pad_full;
    logic [1:0] pad;

    assign three_w_mod = {2'b00, width_q[1:0]} * 4'd3;
    assign pad_full    = 3'd4 - {1'b0, three_w_mod[1:0]};
    assign pad         = pad_full[1:0];
    assign row_step    = ADDR_W'(3) + ADDR_W'(pad);
`else
    assign row_step = ADDR_W'(3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            width_q  <= width_d;
            height_q <= height_d;
            col_q    <= col_d;
            row_q    <= row_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        red_d    = red_q;
        green_d  = green_q;
        blue_d   = blue_q;
        busy_d   = busy_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (width_i == '0 || height_i == '0) begin
                        state_d = FIN;
                    end else begin
                        addr_d   = base_addr_i;
                        width_d  = width_i;
                        height_d = height_i;
                        col_d    = '0;
                        row_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = RD0;
                    end
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                blue_d  = mem_data_i;
                state_d = RD2;
            end
            RD2: begin
                green_d = mem_data_i;
                state_d = CAP;
            end
            CAP: begin
                red_d   = mem_data_i;
                state_d = OUT;
            end
            OUT: begin
                if (ready_i) begin
                    if (last_col && last_row) begin
                        busy_d  = 1'b0;
                        state_d = FIN;
                    end else if (last_col) begin
                        col_d   = '0;
                        row_d   = row_q + DIM_W'(1);
                        addr_d  = addr_q + row_step;
                        state_d = RD0;
                    end else begin
                        col_d   = col_q + DIM_W'(1);
                        addr_d  = addr_q + ADDR_W'(3);
                        state_d = RD0;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode the state register only, so ready_i never reaches an output combinationally.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_addr_o = '0;
        case (state_q)
            RD0: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = addr_q;
            end
            RD1: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = addr_q + ADDR_W'(1);
            end
            RD2: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = addr_q + ADDR_W'(2);
            end
            default: begin
                mem_rd_o   = 1'b0;
                mem_addr_o = '0;
            end
        endcase
    end

    assign done_o       = (state_q == OUT);
    assign frame_done_o = (state_q == FIN);
    assign busy_o       = busy_q;
    assign red_o        = red_q;
    assign green_o      = green_q;
    assign blue_o       = blue_q;

endmodule

// File: tb/tb_bmp_pixel_source.sv
// Directed self-checking bench for bmp_pixel_source; memory byte k holds k[7:0].
// Also compiles with ROW_PAD_EN defined to cover the padded-row build.
module tb_bmp_pixel_source;

    localparam int ADDR_W = 20;
    localparam int DIM_W  = 12;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [DIM_W-1:0]  width_i;
    logic [DIM_W-1:0]  height_i;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i;
    logic              ready_i;
    logic [7:0]        red_o;
    logic [7:0]        green_o;
    logic [7:0]        blue_o;
    logic              done_o;
    logic              busy_o;
    logic              frame_done_o;

    int testsRun  = 0;
    int failCount = 0;

    int pixCount      = 0;
    int rdCount       = 0;
    int fdCount       = 0;
    int doneCycles    = 0;
    int cycleCount    = 0;
    int lastXferCycle = 0;
    int fdCycle       = 0;
    logic fdBusy      = 1'b0;

    logic [ADDR_W-1:0] rdAddr [0:511];
    logic [23:0]       pixVal [0:127];

    bmp_pixel_source #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .width_i      (width_i),
        .height_i     (height_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_i   (mem_data_i),
        .ready_i      (ready_i),
        .red_o        (red_o),
        .green_o      (green_o),
        .blue_o       (blue_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory with one-cycle read latency; unread cycles return a marker byte.
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= mem_addr_o[7:0];
        else          mem_data_i <= 8'hEE;
    end

    // Records reads, pixel transfers and frame-done pulses on the falling edge.
    always @(negedge clk) begin
        cycleCount++;
        if (rst_n) begin
            if (mem_rd_o) begin
                if (rdCount < 512) rdAddr[rdCount] = mem_addr_o;
                rdCount++;
            end
            if (done_o) doneCycles++;
            if (done_o && ready_i) begin
                if (pixCount < 128) pixVal[pixCount] = {red_o, green_o, blue_o};
                pixCount++;
                lastXferCycle = cycleCount;
            end
            if (frame_done_o) begin
                fdCount++;
                fdCycle = cycleCount;
                fdBusy  = busy_o;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pulses start_i for one accepted edge; returns 1ns into the first cycle after it.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int w, input int h);
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = base;
        width_i     = DIM_W'(w);
        height_i    = DIM_W'(h);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic waitFrameDone(input int fd0, input string tag);
        int n = 0;
        while (fdCount == fd0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, 32'(fdCount - fd0), 32'd1);
        #1;
    endtask

    function automatic logic [23:0] expPixel(input int addr);
        logic [7:0] b;
        b = 8'(addr);
        return {8'(b + 8'd2), 8'(b + 8'd1), b};
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pix0, rd0, fd0, dc0, n, errs, expAddr;

        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        width_i     = '0;
        height_i    = '0;
        ready_i     = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset done_o", 32'(done_o), 32'd0);
        checkOutput("reset mem_rd_o", 32'(mem_rd_o), 32'd0);
        checkOutput("reset busy_o", 32'(busy_o), 32'd0);
        checkOutput("reset frame_done_o", 32'(frame_done_o), 32'd0);
        checkOutput("reset rgb", {8'h0, red_o, green_o, blue_o}, 32'd0);
        checkOutput("reset mem_addr_o", 32'(mem_addr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4x2 frame with ready tied high
        pix0 = pixCount; rd0 = rdCount; fd0 = fdCount;
        applyStimulus(20'h0, 4, 2);
        checkOutput("t1 busy after start", 32'(busy_o), 32'd1);
        checkOutput("t1 first rd", 32'(mem_rd_o), 32'd1);
        checkOutput("t1 first addr", 32'(mem_addr_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t1 done before latency", 32'(done_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t1 done at cycle 5", 32'(done_o), 32'd1);
        checkOutput("t1 pixel0 rgb", {8'h0, red_o, green_o, blue_o}, 32'h00020100);
        waitFrameDone(fd0, "t1 frame_done seen");
        checkOutput("t1 pixel count", 32'(pixCount - pix0), 32'd8);
        checkOutput("t1 read count", 32'(rdCount - rd0), 32'd24);
        errs = 0;
        for (int i = 0; i < 8; i++)
            if (pixVal[pix0 + i] !== expPixel(3 * i)) errs++;
        checkOutput("t1 pixel values errs", 32'(errs), 32'd0);
        checkOutput("t1 pixel7 rgb", {8'h0, pixVal[pix0 + 7]}, 32'h00171615);
        checkOutput("t1 frame_done after last xfer", 32'(fdCycle - lastXferCycle), 32'd1);
        checkOutput("t1 busy low with frame_done", 32'(fdBusy), 32'd0);
        checkOutput("t1 frame_done one cycle", 32'(frame_done_o), 32'd0);

        // Back-pressure: three stalled cycles on the first pixel
        pix0 = pixCount; rd0 = rdCount; fd0 = fdCount; dc0 = doneCycles;
        ready_i = 1'b0;
        applyStimulus(20'h0, 4, 2);
        n = 0;
        while (!done_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t2 done reached", 32'(done_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t2 done held in stall", 32'(done_o), 32'd1);
        checkOutput("t2 rgb held in stall", {8'h0, red_o, green_o, blue_o}, 32'h00020100);
        @(posedge clk);
        #1;
        checkOutput("t2 done 4th cycle", 32'(done_o), 32'd1);
        checkOutput("t2 no reads during stall", 32'(rdCount - rd0), 32'd3);
        ready_i = 1'b1;
        waitFrameDone(fd0, "t2 frame_done seen");
        checkOutput("t2 done cycles", 32'(doneCycles - dc0), 32'd11);
        checkOutput("t2 pixel count", 32'(pixCount - pix0), 32'd8);
        checkOutput("t2 pixel1 addr0", 32'(rdAddr[rd0 + 3]), 32'd3);
        checkOutput("t2 pixel1 addr1", 32'(rdAddr[rd0 + 4]), 32'd4);
        checkOutput("t2 pixel1 addr2", 32'(rdAddr[rd0 + 5]), 32'd5);

        // Zero-width frame
        pix0 = pixCount; rd0 = rdCount; dc0 = doneCycles;
        applyStimulus(20'h0, 0, 5);
        checkOutput("t3 frame_done after start", 32'(frame_done_o), 32'd1);
        checkOutput("t3 busy stays low", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t3 frame_done one cycle", 32'(frame_done_o), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t3 no reads", 32'(rdCount - rd0), 32'd0);
        checkOutput("t3 no done", 32'(doneCycles - dc0), 32'd0);
        checkOutput("t3 no pixels", 32'(pixCount - pix0), 32'd0);

        // Start pulsed mid-frame must be ignored
        pix0 = pixCount; rd0 = rdCount; fd0 = fdCount;
        applyStimulus(20'h0, 4, 2);
        repeat (6) @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = 20'h100;
        width_i     = 12'd2;
        height_i    = 12'd1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waitFrameDone(fd0, "t4 frame_done seen");
        checkOutput("t4 pixel count", 32'(pixCount - pix0), 32'd8);
        checkOutput("t4 read count", 32'(rdCount - rd0), 32'd24);
        errs = 0;
        for (int j = 0; j < 24; j++)
            if (rdAddr[rd0 + j] !== ADDR_W'(j)) errs++;
        checkOutput("t4 read address errs", 32'(errs), 32'd0);
        checkOutput("t4 pixel7 rgb", {8'h0, pixVal[pix0 + 7]}, 32'h00171615);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4 idle after frame", 32'(busy_o), 32'd0);

        // Asynchronous reset during RD1 of pixel 3 (address 10)
        fd0 = fdCount;
        applyStimulus(20'h0, 4, 2);
        n = 0;
        while (!(mem_rd_o && mem_addr_o == 20'd10) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t5 reached RD1 of pixel3", 32'(mem_addr_o), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5 async rd low", 32'(mem_rd_o), 32'd0);
        checkOutput("t5 async addr zero", 32'(mem_addr_o), 32'd0);
        checkOutput("t5 async busy low", 32'(busy_o), 32'd0);
        checkOutput("t5 async rgb zero", {8'h0, red_o, green_o, blue_o}, 32'd0);
        checkOutput("t5 async done low", 32'(done_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5 no frame_done on abort", 32'(fdCount - fd0), 32'd0);
        checkOutput("t5 stays idle", 32'(busy_o), 32'd0);
        pix0 = pixCount; fd0 = fdCount;
        applyStimulus(20'h40, 4, 1);
        waitFrameDone(fd0, "t5 restart frame_done seen");
        checkOutput("t5 restart pixel count", 32'(pixCount - pix0), 32'd4);
        checkOutput("t5 restart pixel0", {8'h0, pixVal[pix0]}, 32'h00424140);

        // Width 3: second row start depends on row padding
        pix0 = pixCount; rd0 = rdCount; fd0 = fdCount;
`ifdef ROW_PAD_EN
        expAddr = 12;
`else
        expAddr = 9;
`endif
        applyStimulus(20'h0, 3, 2);
        waitFrameDone(fd0, "t6 frame_done seen");
        checkOutput("t6 pixel count", 32'(pixCount - pix0), 32'd6);
        checkOutput("t6 row1 first addr", 32'(rdAddr[rd0 + 9]), 32'(expAddr));
        checkOutput("t6 row1 pixel0", {8'h0, pixVal[pix0 + 3]}, {8'h0, expPixel(expAddr)});
        checkOutput("t6 last pixel", {8'h0, pixVal[pix0 + 5]}, {8'h0, expPixel(expAddr + 6)});

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
